// File: rtl/masked_alu_pkg.sv
// Shared types for the masked add/sub unit and its checkers.
//   state_e      : FSM states of masked_alu_addsub
//   share2_t     : 2-share masked word at the default datapath width
//   unmask_bool  : recombine a Boolean-masked word   (s0 ^ s1)
//   unmask_arith : recombine an arithmetic-masked word (s0 + s1 mod 2^W)
package masked_alu_pkg;

  localparam int unsigned MASK_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    ARITH,
    PREP,
    ROUND,
    FINAL,
    DONE
  } state_e;

  typedef struct packed {
    logic [MASK_W-1:0] s1;
    logic [MASK_W-1:0] s0;
  } share2_t;

  function automatic logic [MASK_W-1:0] unmask_bool(input share2_t x);
    return x.s0 ^ x.s1;
  endfunction

  function automatic logic [MASK_W-1:0] unmask_arith(input share2_t x);
    return x.s0 + x.s1;
  endfunction

endpackage

// File: rtl/masked_dom_and.sv
// Domain-oriented masked AND, one register stage.
//   x0,x1 / y0,y1 : Boolean shares of the two operands
//   r             : fresh randomness for the two cross terms
//   z0,z1         : Boolean shares of x & y, valid one cycle after the inputs
// Every product term is registered before the output XOR, so no
// combinational path mixes the two share domains.
module masked_dom_and #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] y1,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] z0,
  output logic [WIDTH-1:0] z1
);

  logic [WIDTH-1:0] r_t00, r_t01, r_t11, r_t10;

  // Inner-domain products and remasked cross-domain products.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_t00 <= '0;
      r_t01 <= '0;
      r_t11 <= '0;
      r_t10 <= '0;
    end else begin
      r_t00 <= x0 & y0;
      r_t01 <= (x0 & y1) ^ r;
      r_t11 <= x1 & y1;
      r_t10 <= (x1 & y0) ^ r;
    end
  end

  assign z0 = r_t00 ^ r_t01;
  assign z1 = r_t11 ^ r_t10;

endmodule

// File: rtl/masked_alu_addsub.sv
// Multi-cycle 2-share masked adder (optional subtract).
//   g_clk, g_resetn           : clock, async active-low reset
//   req_valid/req_ready       : request handshake (ready = idle)
//   req_bool                  : 1 Boolean masking, 0 arithmetic masking
//   req_sub                   : subtract rs1-rs2 (only with MASKED_ALU_SUB_EN)
//   req_a0/a1, req_b0/b1      : operand shares
//   prng                      : fresh randomness, low half G path, high half P path
//   flush                     : abort any busy state, no response
//   rsp_valid/rsp_ready       : response handshake, rsp_r0/rsp_r1 result shares
// Build macro: MASKED_ALU_SUB_EN enables subtraction.
module masked_alu_addsub
  import masked_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LOG2W = $clog2(WIDTH)
) (
  input  logic               g_clk,
  input  logic               g_resetn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_bool,
  input  logic               req_sub,
  input  logic [WIDTH-1:0]   req_a0,
  input  logic [WIDTH-1:0]   req_a1,
  input  logic [WIDTH-1:0]   req_b0,
  input  logic [WIDTH-1:0]   req_b1,
  input  logic [2*WIDTH-1:0] prng,
  input  logic               flush,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_r0,
  output logic [WIDTH-1:0]   rsp_r1
);

  localparam int unsigned CNT_W = (LOG2W > 2) ? $clog2(LOG2W) : 1;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a0, r_a1, r_b0, r_b1;
  logic [WIDTH-1:0] r_p0, r_p1;          // original propagate a^b'
  logic [WIDTH-1:0] r_gacc0, r_gacc1;    // generate term carried into the next XOR
  logic             r_req_ready, r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_r0, r_rsp_r1;

  logic             w_sub;
  logic [WIDTH-1:0] w_bp0, w_pp0, w_pp1;
  logic [WIDTH-1:0] w_gz0, w_gz1, w_pz0, w_pz1;
  logic [WIDTH-1:0] w_g0, w_g1, w_p0, w_p1;
  logic [WIDTH-1:0] w_gx0, w_gx1, w_gy0, w_gy1;
  logic [LOG2W-1:0] w_dist;

`ifdef MASKED_ALU_SUB_EN
  logic r_sub;
  assign w_sub = r_sub;
`else
  logic w_unused_sub;
  assign w_unused_sub = req_sub;
  assign w_sub        = 1'b0;
`endif

  // Subtraction complements b in share 0 only; the +1 comes in as carry-in.
  assign w_bp0 = w_sub ? ~r_b0 : r_b0;
  assign w_pp0 = r_a0 ^ w_bp0;
  assign w_pp1 = r_a1 ^ r_b1;

  // Current prefix values: G = held term ^ latest AND output; P comes from
  // the original register in the first round and the P-path AND afterwards.
  assign w_g0   = r_gacc0 ^ w_gz0;
  assign w_g1   = r_gacc1 ^ w_gz1;
  assign w_p0   = (r_cnt == '0) ? r_p0 : w_pz0;
  assign w_p1   = (r_cnt == '0) ? r_p1 : w_pz1;
  assign w_dist = LOG2W'(1) << r_cnt;

  // G-path AND operands: a & b' in PREP, P & (G<<d) in ROUND.
  always_comb begin
    w_gx0 = w_p0;
    w_gx1 = w_p1;
    w_gy0 = w_g0 << w_dist;
    w_gy1 = w_g1 << w_dist;
    if (r_state == PREP) begin
      w_gx0 = r_a0;
      w_gx1 = r_a1;
      w_gy0 = w_bp0;
      w_gy1 = r_b1;
    end
  end

  masked_dom_and #(.WIDTH(WIDTH)) u_dom_g (
    .g_clk   (g_clk),
    .g_resetn(g_resetn),
    .x0      (w_gx0),
    .x1      (w_gx1),
    .y0      (w_gy0),
    .y1      (w_gy1),
    .r       (prng[WIDTH-1:0]),
    .z0      (w_gz0),
    .z1      (w_gz1)
  );

  masked_dom_and #(.WIDTH(WIDTH)) u_dom_p (
    .g_clk   (g_clk),
    .g_resetn(g_resetn),
    .x0      (w_p0),
    .x1      (w_p1),
    .y0      (w_p0 << w_dist),
    .y1      (w_p1 << w_dist),
    .r       (prng[2*WIDTH-1:WIDTH]),
    .z0      (w_pz0),
    .z1      (w_pz1)
  );

  // Control FSM with registered outputs; flush beats any handshake.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_a0        <= '0;
      r_a1        <= '0;
      r_b0        <= '0;
      r_b1        <= '0;
      r_p0        <= '0;
      r_p1        <= '0;
      r_gacc0     <= '0;
      r_gacc1     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_r0    <= '0;
      r_rsp_r1    <= '0;
`ifdef MASKED_ALU_SUB_EN
      r_sub       <= 1'b0;
`endif
    end else if (flush && (r_state != IDLE)) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_a0        <= req_a0;
            r_a1        <= req_a1;
            r_b0        <= req_b0;
            r_b1        <= req_b1;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_state     <= req_bool ? PREP : ARITH;
`ifdef MASKED_ALU_SUB_EN
            r_sub       <= req_sub;
`endif
          end
        end
        ARITH: begin
          r_rsp_r0    <= w_sub ? (r_a0 - r_b0) : (r_a0 + r_b0);
          r_rsp_r1    <= w_sub ? (r_a1 - r_b1) : (r_a1 + r_b1);
          r_rsp_valid <= 1'b1;
          r_state     <= DONE;
        end
        PREP: begin
          r_p0    <= w_pp0;
          r_p1    <= w_pp1;
          // Carry-in of 1 turns bit-0 generate into a|b = g^p, sharewise linear.
          r_gacc0 <= {{(WIDTH-1){1'b0}}, w_sub & w_pp0[0]};
          r_gacc1 <= {{(WIDTH-1){1'b0}}, w_sub & w_pp1[0]};
          r_cnt   <= '0;
          r_state <= ROUND;
        end
        ROUND: begin
          r_gacc0 <= w_g0;
          r_gacc1 <= w_g1;
          if (r_cnt == CNT_W'(LOG2W - 1)) begin
            r_state <= FINAL;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        FINAL: begin
          // Carry-in enters share 0 only; each share keeps its own G half.
          r_rsp_r0    <= r_p0 ^ {w_g0[WIDTH-2:0], w_sub};
          r_rsp_r1    <= r_p1 ^ {w_g1[WIDTH-2:0], 1'b0};
          r_rsp_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_r0    = r_rsp_r0;
  assign rsp_r1    = r_rsp_r1;

endmodule

// File: tb/tb_masked_alu_addsub.sv
// Directed bench for masked_alu_addsub with a result scoreboard.
module tb_masked_alu_addsub;

  localparam int unsigned W     = 32;
  localparam int          LAT_A = 2;
  localparam int          LAT_B = 8;

  logic           g_clk = 1'b0;
  logic           g_resetn;
  logic           req_valid, req_ready, req_bool, req_sub;
  logic [W-1:0]   req_a0, req_a1, req_b0, req_b1;
  logic [2*W-1:0] prng;
  logic           flush;
  logic           rsp_valid, rsp_ready;
  logic [W-1:0]   rsp_r0, rsp_r1;

  typedef struct {
    logic         bool_m;
    logic [W-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  masked_alu_addsub #(.WIDTH(W)) dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_bool (req_bool),
    .req_sub  (req_sub),
    .req_a0   (req_a0),
    .req_a1   (req_a1),
    .req_b0   (req_b0),
    .req_b1   (req_b1),
    .prng     (prng),
    .flush    (flush),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_r0   (rsp_r0),
    .rsp_r1   (rsp_r1)
  );

  always #5 g_clk = ~g_clk;

  always @(negedge g_clk) prng = {$urandom(), $urandom()};

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] unmask(input logic bm);
    return bm ? (rsp_r0 ^ rsp_r1) : (rsp_r0 + rsp_r1);
  endfunction

  function automatic logic [W-1:0] model(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MASKED_ALU_SUB_EN
    return sub ? (a - b) : (a + b);
`else
    return a + b;
`endif
  endfunction

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic send_sh(input string tag, input logic bm, input logic sub,
                         input logic [W-1:0] a0, input logic [W-1:0] a1,
                         input logic [W-1:0] b0, input logic [W-1:0] b1,
                         input logic [W-1:0] expv, input bit push);
    check({tag, " req_ready"}, W'(req_ready), W'(1));
    req_valid = 1'b1;
    req_bool  = bm;
    req_sub   = sub;
    req_a0    = a0;
    req_a1    = a1;
    req_b0    = b0;
    req_b1    = b1;
    if (push) sb.push_back('{bm, expv});
    @(posedge g_clk);
    @(negedge g_clk);
    req_valid = 1'b0;
  endtask

  task automatic send_val(input string tag, input logic bm, input logic sub,
                          input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] m, n;
    m = $urandom();
    n = $urandom();
    if (bm) send_sh(tag, bm, sub, m, a ^ m, n, b ^ n, model(sub, a, b), 1'b1);
    else    send_sh(tag, bm, sub, m, a - m, n, b - n, model(sub, a, b), 1'b1);
  endtask

  task automatic collect(input string tag, input int lat, input int stall, input bit intrude);
    int           edges;
    exp_t         e;
    logic [W-1:0] hold0, hold1;
    edges = 1;
    while (rsp_valid !== 1'b1 && edges < 40) begin
      @(posedge g_clk);
      @(negedge g_clk);
      edges++;
    end
    check({tag, " latency"}, W'(edges), W'(lat));
    e.bool_m = 1'b0;
    e.val    = 'x;
    if (sb.size() > 0) e = sb.pop_front();
    check({tag, " result"}, unmask(e.bool_m), e.val);
    hold0 = rsp_r0;
    hold1 = rsp_r1;
    for (int i = 0; i < stall; i++) begin
      if (intrude) begin
        req_valid = 1'b1;
        req_bool  = 1'b0;
        req_a0    = $urandom();
        req_b0    = $urandom();
      end
      @(posedge g_clk);
      @(negedge g_clk);
      check({tag, " stall share0"}, rsp_r0, hold0);
      check({tag, " stall share1"}, rsp_r1, hold1);
      check({tag, " stall rsp_valid"}, W'(rsp_valid), W'(1));
      check({tag, " stall req_ready"}, W'(req_ready), W'(0));
      check({tag, " stall result"}, unmask(e.bool_m), e.val);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    rsp_ready = 1'b0;
    check({tag, " post rsp_valid"}, W'(rsp_valid), W'(0));
    check({tag, " post req_ready"}, W'(req_ready), W'(1));
  endtask

  // Confirms no response shows up over a quiet window.
  task automatic quiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge g_clk);
      seen = seen | rsp_valid;
    end
    check({tag, " no response"}, W'(seen), W'(0));
  endtask

  initial begin
    logic [W-1:0] m, n, exp_bsub, exp_asub;
    g_resetn  = 1'b0;
    req_valid = 1'b0;
    req_bool  = 1'b0;
    req_sub   = 1'b0;
    req_a0    = '0;
    req_a1    = '0;
    req_b0    = '0;
    req_b1    = '0;
    flush     = 1'b0;
    rsp_ready = 1'b0;
    prng      = '0;
`ifdef MASKED_ALU_SUB_EN
    exp_bsub = 32'hFFFF_FFFE;
    exp_asub = 32'd7;
`else
    exp_bsub = 32'h0000_000C;
    exp_asub = 32'd13;
`endif

    repeat (3) @(negedge g_clk);
    check("reset req_ready", W'(req_ready), W'(1));
    check("reset rsp_valid", W'(rsp_valid), W'(0));
    check("reset rsp_r0", rsp_r0, '0);
    check("reset rsp_r1", rsp_r1, '0);
    g_resetn = 1'b1;
    @(negedge g_clk);

    // Arithmetic add: 1 + 1.
    send_sh("arith_add", 1'b0, 1'b0, 32'h1234_5678, 32'hEDCB_A989,
            32'h0F0F_0F0F, 32'hF0F0_F0F2, 32'd2, 1'b1);
    collect("arith_add", LAT_A, 0, 1'b0);

    // Boolean add with a full carry chain wrapping to zero.
    m = $urandom();
    n = $urandom();
    send_sh("bool_wrap", 1'b1, 1'b0, m, ~m, n, n ^ 32'd1, 32'd0, 1'b1);
    collect("bool_wrap", LAT_B, 0, 1'b0);

    // Boolean 5 - 7, and arithmetic 10 - 3.
    m = $urandom();
    n = $urandom();
    send_sh("bool_sub", 1'b1, 1'b1, m, m ^ 32'd5, n, n ^ 32'd7, exp_bsub, 1'b1);
    collect("bool_sub", LAT_B, 0, 1'b0);
    m = $urandom();
    n = $urandom();
    send_sh("arith_sub", 1'b0, 1'b1, m, 32'd10 - m, n, 32'd3 - n, exp_asub, 1'b1);
    collect("arith_sub", LAT_A, 0, 1'b0);

    // Boundary operands and random traffic in both domains.
    send_val("bool_max", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    collect("bool_max", LAT_B, 0, 1'b0);
    send_val("bool_msb", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
    collect("bool_msb", LAT_B, 0, 1'b0);
    send_val("bool_zero_sub", 1'b1, 1'b1, 32'd0, 32'd0);
    collect("bool_zero_sub", LAT_B, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      bit bm, sub;
      bm  = (i % 2) == 1;
      sub = (i / 2) == 1;
      send_val("rand", bm, sub, $urandom(), $urandom());
      collect("rand", bm ? LAT_B : LAT_A, 0, 1'b0);
    end

    // Backpressure with an ignored request during the stall.
    send_val("backpressure", 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0123_4567);
    collect("backpressure", LAT_B, 5, 1'b1);
    quiet("backpressure", 10);

    // Flush during ROUND cnt=2, then an arithmetic op.
    m = $urandom();
    send_sh("flush", 1'b1, 1'b0, m, m ^ 32'd9, 32'd0, 32'd4, 32'd0, 1'b0);
    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    flush = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    flush = 1'b0;
    check("flush req_ready", W'(req_ready), W'(1));
    check("flush rsp_valid", W'(rsp_valid), W'(0));
    quiet("flush", 10);
    send_val("after_flush", 1'b0, 1'b0, 32'd100, 32'd23);
    collect("after_flush", LAT_A, 0, 1'b0);

    // Asynchronous reset in the middle of a Boolean op.
    m = $urandom();
    send_sh("reset_mid", 1'b1, 1'b0, m, m ^ 32'd3, 32'd0, 32'd3, 32'd0, 1'b0);
    repeat (3) @(posedge g_clk);
    #2;
    g_resetn = 1'b0;
    #1;
    check("reset_mid req_ready", W'(req_ready), W'(1));
    check("reset_mid rsp_valid", W'(rsp_valid), W'(0));
    check("reset_mid rsp_r0", rsp_r0, '0);
    check("reset_mid rsp_r1", rsp_r1, '0);
    @(negedge g_clk);
    g_resetn = 1'b1;
    @(negedge g_clk);
    send_val("after_reset", 1'b0, 1'b0, 32'h7FFF_FFFF, 32'd1);
    collect("after_reset", LAT_A, 0, 1'b0);
    quiet("after_reset", 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
